// File: rtl/gmcu_bitio_ctrl_pkg.sv
// Shared types for the bit-addressed IO controller: FSM state and captured request.
// Field widths follow the platform IO space; the controller accepts narrower parameters.
package gmcupkg;

  localparam int unsigned GMCU_IO_ADDR_W = 8;
  localparam int unsigned GMCU_IO_DATA_W = 8;
  localparam int unsigned GMCU_IO_BSEL_W = $clog2(GMCU_IO_DATA_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RSP  = 2'd3
  } bitioStateType;

  typedef struct packed {
    logic [GMCU_IO_ADDR_W-1:0] addr;
    logic [GMCU_IO_BSEL_W-1:0] bitsel;
    logic                      bitval;
    logic                      store;
  } bitioReqType;

endpackage

// File: rtl/gmcu_bitio_ctrl_if.sv
// Signal bundle around gmcu_bitio_ctrl: decode request/response plus the IO bus.
// master = decode and IO fabric side, slave = the bit-op controller.
interface gmcu_bitio_ctrl_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  localparam int unsigned BSEL_W = $clog2(DATA_W)
) ();

  // Handshakes: a request transfers at the rising edge where req_valid & req_ready;
  // rsp_valid is a single-cycle pulse with no backpressure; on the IO bus io_req stays
  // high with io_addr/io_we/io_wdata frozen until the edge that samples io_ack high.
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [ADDR_W-1:0] req_addr;
  logic [BSEL_W-1:0] req_bitsel;
  logic              req_bitval;
  logic              rsp_valid;
  logic              rsp_bit;
  logic              rsp_err;
  logic              io_req;
  logic              io_we;
  logic [ADDR_W-1:0] io_addr;
  logic [DATA_W-1:0] io_wdata;
  logic              io_ack;
  logic [DATA_W-1:0] io_rdata;

  modport master (
    output req_valid, req_store, req_addr, req_bitsel, req_bitval, io_ack, io_rdata,
    input  req_ready, rsp_valid, rsp_bit, rsp_err, io_req, io_we, io_addr, io_wdata
  );

  modport slave (
    input  req_valid, req_store, req_addr, req_bitsel, req_bitval, io_ack, io_rdata,
    output req_ready, rsp_valid, rsp_bit, rsp_err, io_req, io_we, io_addr, io_wdata
  );

endinterface

// File: rtl/gmcu_bitio_ctrl_tmo.sv
// Bus-wait watchdog for gmcu_bitio_ctrl; only built with GMCU_BITIO_TIMEOUT_EN defined.
// expired is high during the TMO_CYC-th consecutive run cycle after a start.
`ifdef GMCU_BITIO_TIMEOUT_EN
module gmcu_bitio_tmo #(
  parameter int unsigned TMO_CYC = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TMO_CYC + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TMO_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = run && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (run && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/gmcu_bitio_ctrl.sv
// Single-bit load/store to an IO register via read (and read-modify-write) on the IO bus.
// Optional bus timeout: define GMCU_BITIO_TIMEOUT_EN to abandon stalled accesses.
module gmcu_bitio_ctrl
  import gmcupkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TMO_CYC = 15,
  localparam int unsigned BSEL_W = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [BSEL_W-1:0] req_bitsel,
  input  logic              req_bitval,
  output logic              rsp_valid,
  output logic              rsp_bit,
  output logic              rsp_err,
  output logic              io_req,
  output logic              io_we,
  output logic [ADDR_W-1:0] io_addr,
  output logic [DATA_W-1:0] io_wdata,
  input  logic              io_ack,
  input  logic [DATA_W-1:0] io_rdata,
  output bitioStateType     dbg_state
);

  if (DATA_W < 2 || (DATA_W & (DATA_W - 1)) != 0 || DATA_W > GMCU_IO_DATA_W ||
      ADDR_W > GMCU_IO_ADDR_W || TMO_CYC < 1) begin : g_bad_params
    $error("gmcu_bitio_ctrl: unsupported ADDR_W/DATA_W/TMO_CYC");
  end

  bitioStateType     state_q, state_d;
  bitioReqType       cap_q, cap_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_bit_q, rsp_bit_d;
  logic [BSEL_W-1:0] sel_bit;

  assign sel_bit   = cap_q.bitsel[BSEL_W-1:0];
  assign req_ready = (state_q == IDLE);
  assign io_req    = (state_q == RD) || (state_q == WR);
  assign io_we     = (state_q == WR);
  assign io_addr   = cap_q.addr[ADDR_W-1:0];
  assign io_wdata  = wdata_q;
  assign rsp_valid = (state_q == RSP);
  assign rsp_bit   = rsp_bit_q;
  assign dbg_state = state_q;

`ifdef GMCU_BITIO_TIMEOUT_EN
  logic rsp_err_q, rsp_err_d;
  logic tmo_start, tmo_expired;

  assign rsp_err = rsp_err_q;

  gmcu_bitio_tmo #(
    .TMO_CYC (TMO_CYC)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (tmo_start),
    .run     (io_req),
    .expired (tmo_expired)
  );
`else
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cap_d     = cap_q;
    wdata_d   = wdata_q;
    rsp_bit_d = rsp_bit_q;
`ifdef GMCU_BITIO_TIMEOUT_EN
    rsp_err_d = rsp_err_q;
    tmo_start = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          cap_d.addr   = GMCU_IO_ADDR_W'(req_addr);
          cap_d.bitsel = GMCU_IO_BSEL_W'(req_bitsel);
          cap_d.bitval = req_bitval;
          cap_d.store  = req_store;
          state_d      = RD;
`ifdef GMCU_BITIO_TIMEOUT_EN
          tmo_start    = 1'b1;
          rsp_err_d    = 1'b0;
`endif
        end
      end
      RD: begin
        if (io_ack) begin
          if (cap_q.store) begin
            // Write back the register just read with only the selected bit replaced.
            wdata_d          = io_rdata;
            wdata_d[sel_bit] = cap_q.bitval;
            rsp_bit_d        = cap_q.bitval;
            state_d          = WR;
`ifdef GMCU_BITIO_TIMEOUT_EN
            tmo_start        = 1'b1;
`endif
          end else begin
            rsp_bit_d = io_rdata[sel_bit];
            state_d   = RSP;
          end
        end
`ifdef GMCU_BITIO_TIMEOUT_EN
        else if (tmo_expired) begin
          rsp_bit_d = 1'b0;
          rsp_err_d = 1'b1;
          state_d   = RSP;
        end
`endif
      end
      WR: begin
        if (io_ack) begin
          state_d = RSP;
        end
`ifdef GMCU_BITIO_TIMEOUT_EN
        else if (tmo_expired) begin
          rsp_bit_d = 1'b0;
          rsp_err_d = 1'b1;
          state_d   = RSP;
        end
`endif
      end
      RSP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cap_q     <= '0;
      wdata_q   <= '0;
      rsp_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cap_q     <= cap_d;
      wdata_q   <= wdata_d;
      rsp_bit_q <= rsp_bit_d;
    end
  end

`ifdef GMCU_BITIO_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= rsp_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_gmcu_bitio_ctrl.sv
// Self-checking bench for gmcu_bitio_ctrl: directed table, randomized ops against a
// behavioural model, and hand-written reset / spurious-ack / back-to-back sequences.
module tb_gmcu_bitio_ctrl;
  import gmcupkg::*;

  localparam int TMO = 15;

  typedef struct {
    logic       store;
    logic [7:0] addr;
    logic [2:0] bitsel;
    logic       bitval;
    logic [7:0] rdata;
    int         rd_dly;
    int         wr_dly;
    logic       exp_bit;
    logic       exp_err;
    logic [7:0] exp_wdata;
    int         exp_lat;
    int         exp_acks;
    int         exp_we;
  } vec_t;

  logic clk;
  logic rst_n;
  bitioStateType dbg_state;

  gmcu_bitio_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  gmcu_bitio_ctrl #(.ADDR_W(8), .DATA_W(8), .TMO_CYC(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (bus.req_valid),
    .req_ready  (bus.req_ready),
    .req_store  (bus.req_store),
    .req_addr   (bus.req_addr),
    .req_bitsel (bus.req_bitsel),
    .req_bitval (bus.req_bitval),
    .rsp_valid  (bus.rsp_valid),
    .rsp_bit    (bus.rsp_bit),
    .rsp_err    (bus.rsp_err),
    .io_req     (bus.io_req),
    .io_we      (bus.io_we),
    .io_addr    (bus.io_addr),
    .io_wdata   (bus.io_wdata),
    .io_ack     (bus.io_ack),
    .io_rdata   (bus.io_rdata),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_chk = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] addr_log[$];
  int dly_rd, dly_wr, waits, n_wr, n_we, n_ack, stab_err;
  logic prev_req, prev_ack, p_we;
  logic [7:0] p_addr, p_wdata, rdata_cfg, last_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_bus_log();
    n_wr = 0; n_we = 0; n_ack = 0; stab_err = 0; waits = 0;
    prev_req = 1'b0; prev_ack = 1'b0;
    addr_log.delete();
  endtask

  // IO responder, called once per cycle #1 after the rising edge: acks after the
  // configured number of wait cycles and logs what the controller presented.
  task automatic bus_sample();
    if (bus.io_req) begin
      if (prev_req && !prev_ack &&
          (bus.io_addr !== p_addr || bus.io_we !== p_we || bus.io_wdata !== p_wdata))
        stab_err++;
      if (bus.io_we) n_we++;
      if (waits >= (bus.io_we ? dly_wr : dly_rd)) begin
        bus.io_ack = 1'b1;
        bus.io_rdata = rdata_cfg;
        n_ack++;
        addr_log.push_back(bus.io_addr);
        if (bus.io_we) begin
          n_wr++;
          last_wdata = bus.io_wdata;
        end
        waits = 0;
      end else begin
        bus.io_ack = 1'b0;
        bus.io_rdata = 8'($urandom);
        waits++;
      end
    end else begin
      bus.io_ack = 1'b0;
      bus.io_rdata = 8'($urandom);
      waits = 0;
    end
    prev_req = bus.io_req;
    prev_ack = bus.io_ack;
    p_addr = bus.io_addr;
    p_we = bus.io_we;
    p_wdata = bus.io_wdata;
  endtask

  // ---------------- reference model ----------------
  function automatic vec_t bus_counts(input vec_t v);
    vec_t e = v;
    if (e.exp_err) begin
      e.exp_acks = 0;
      e.exp_we = 0;
    end else begin
      e.exp_acks = v.store ? 2 : 1;
      e.exp_we = v.store ? v.wr_dly + 1 : 0;
    end
    return e;
  endfunction

  function automatic vec_t predict(input vec_t v);
    vec_t e = v;
    int idx = int'(v.bitsel);
    int word = int'(v.rdata);
    e.exp_err = 1'b0;
    if (v.store) begin
      e.exp_bit = v.bitval;
      word = v.bitval ? (word | (1 << idx)) : (word & ~(1 << idx));
      e.exp_wdata = 8'(word);
      e.exp_lat = 3 + v.rd_dly + v.wr_dly;
    end else begin
      e.exp_bit = ((word >> idx) % 2) == 1;
      e.exp_wdata = 8'h00;
      e.exp_lat = 2 + v.rd_dly;
    end
    return bus_counts(e);
  endfunction

  function automatic vec_t mk(input logic st, input logic [7:0] a, input logic [2:0] b,
                              input logic bv, input logic [7:0] rd, input int drd,
                              input int dwr, input logic eb, input logic ee,
                              input logic [7:0] ew, input int el);
    vec_t v;
    v.store = st; v.addr = a; v.bitsel = b; v.bitval = bv; v.rdata = rd;
    v.rd_dly = drd; v.wr_dly = dwr; v.exp_bit = eb; v.exp_err = ee;
    v.exp_wdata = ew; v.exp_lat = el;
    v.exp_acks = 0; v.exp_we = 0;
    return bus_counts(v);
  endfunction

  // ---------------- driver: one complete operation ----------------
  task automatic do_op(input vec_t v, input string tag);
    int lat, nrsp, ready_bad;
    logic rbit, rerr, req_at_rsp, req_after, ready_after;
    dly_rd = v.rd_dly; dly_wr = v.wr_dly; rdata_cfg = v.rdata;
    clear_bus_log();
    chk({tag, " ready_before"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_store = v.store;
    bus.req_addr = v.addr;
    bus.req_bitsel = v.bitsel;
    bus.req_bitval = v.bitval;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_store = 1'($urandom);
    bus.req_addr = 8'($urandom);
    bus.req_bitsel = 3'($urandom);
    bus.req_bitval = 1'($urandom);
    lat = -1; nrsp = 0; ready_bad = 0;
    rbit = 1'bx; rerr = 1'bx; req_at_rsp = 1'bx; req_after = 1'bx; ready_after = 1'bx;
    for (int c = 1; c <= 60; c++) begin
      if (bus.rsp_valid) begin
        nrsp++;
        if (lat < 0) begin
          lat = c; rbit = bus.rsp_bit; rerr = bus.rsp_err; req_at_rsp = bus.io_req;
        end
      end
      if ((lat < 0 || c == lat) && bus.req_ready) ready_bad++;
      if (lat >= 0 && c == lat + 1) begin
        req_after = bus.io_req;
        ready_after = bus.req_ready;
      end
      bus_sample();
      if (lat >= 0 && c > lat) break;
      @(posedge clk); #1;
    end
    chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, " rsp_count"}, 32'(nrsp), 32'd1);
    chk({tag, " rsp_bit"}, 32'(rbit), 32'(v.exp_bit));
    chk({tag, " rsp_err"}, 32'(rerr), 32'(v.exp_err));
    chk({tag, " io_acks"}, 32'(n_ack), 32'(v.exp_acks));
    chk({tag, " we_cycles"}, 32'(n_we), 32'(v.exp_we));
    chk({tag, " writes"}, 32'(n_wr), 32'((v.store && !v.exp_err) ? 1 : 0));
    if (v.store && !v.exp_err) chk({tag, " io_wdata"}, 32'(last_wdata), 32'(v.exp_wdata));
    foreach (addr_log[i]) chk({tag, " io_addr"}, 32'(addr_log[i]), 32'(v.addr));
    chk({tag, " bus_stable"}, 32'(stab_err), 32'd0);
    chk({tag, " ready_low_busy"}, 32'(ready_bad), 32'd0);
    chk({tag, " io_req_at_rsp"}, 32'(req_at_rsp), 32'd0);
    chk({tag, " io_req_after"}, 32'(req_after), 32'd0);
    chk({tag, " ready_after"}, 32'(ready_after), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl[6];
  vec_t rv;

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_addr = '0;
    bus.req_bitsel = '0; bus.req_bitval = 1'b0; bus.io_ack = 1'b0; bus.io_rdata = '0;
    clear_bus_log();

    tbl[0] = mk(1'b0, 8'h12, 3'd3, 1'b0, 8'h08, 0, 0, 1'b1, 1'b0, 8'h00, 2);
    tbl[1] = mk(1'b1, 8'h20, 3'd0, 1'b1, 8'hA4, 0, 0, 1'b1, 1'b0, 8'hA5, 3);
    tbl[2] = mk(1'b1, 8'h3C, 3'd7, 1'b0, 8'hFF, 4, 4, 1'b0, 1'b0, 8'h7F, 11);
    tbl[3] = mk(1'b0, 8'h81, 3'd7, 1'b0, 8'h80, 1, 0, 1'b1, 1'b0, 8'h00, 3);
    tbl[4] = mk(1'b0, 8'hFF, 3'd0, 1'b1, 8'hFE, 2, 0, 1'b0, 1'b0, 8'h00, 4);
    tbl[5] = mk(1'b1, 8'h00, 3'd4, 1'b1, 8'h00, 2, 1, 1'b1, 1'b0, 8'h10, 6);

    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset io_req", 32'(bus.io_req), 32'd0);
    chk("reset io_we", 32'(bus.io_we), 32'd0);
    chk("reset io_addr", 32'(bus.io_addr), 32'd0);
    chk("reset io_wdata", 32'(bus.io_wdata), 32'd0);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset rsp_bit", 32'(bus.rsp_bit), 32'd0);
    chk("reset rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("reset state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) do_op(tbl[i], $sformatf("tbl%0d", i));

    for (int n = 0; n < 24; n++) begin
      rv.store = 1'($urandom);
      rv.addr = 8'($urandom);
      rv.bitsel = 3'($urandom_range(0, 7));
      rv.bitval = 1'($urandom);
      rv.rdata = 8'($urandom);
      rv.rd_dly = $urandom_range(0, 5);
      rv.wr_dly = $urandom_range(0, 5);
      do_op(predict(rv), $sformatf("rnd%0d", n));
    end

`ifdef GMCU_BITIO_TIMEOUT_EN
    do_op(mk(1'b0, 8'h44, 3'd1, 1'b0, 8'hFF, 1000, 0, 1'b0, 1'b1, 8'h00, TMO + 1), "tmo_load");
    do_op(mk(1'b1, 8'h45, 3'd2, 1'b1, 8'h00, 1000, 0, 1'b0, 1'b1, 8'h00, TMO + 1), "tmo_store");
    do_op(tbl[0], "after_tmo");
`endif

    // Reset while the store is waiting in its write phase.
    begin
      int bad_rsp = 0;
      int bad_req = 0;
      dly_rd = 0; dly_wr = 20; rdata_cfg = 8'h0F;
      clear_bus_log();
      bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_addr = 8'h5A;
      bus.req_bitsel = 3'd6; bus.req_bitval = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus_sample();
      @(posedge clk); #1;
      chk("rst_in_wr io_we", 32'(bus.io_we), 32'd1);
      bus_sample();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.io_ack = 1'b0;
      chk("rst_in_wr io_req", 32'(bus.io_req), 32'd0);
      chk("rst_in_wr req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_in_wr rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_in_wr io_wdata", 32'(bus.io_wdata), 32'd0);
      chk("rst_in_wr io_addr", 32'(bus.io_addr), 32'd0);
      for (int c = 0; c < 6; c++) begin
        @(posedge clk); #1;
        if (bus.rsp_valid) bad_rsp++;
        if (bus.io_req) bad_req++;
      end
      chk("rst_in_wr no_rsp", 32'(bad_rsp), 32'd0);
      chk("rst_in_wr stays_idle", 32'(bad_req), 32'd0);
    end

    // Spurious ack while idle, then req_valid held high across two requests.
    begin
      int bad = 0;
      int accepts = 0;
      int ready_bad = 0;
      logic busy = 1'b0;
      logic take;
      logic got_bits[$];
      bus.io_ack = 1'b1; bus.io_rdata = 8'hFF;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        if (!bus.req_ready || bus.io_req || bus.rsp_valid) bad++;
      end
      bus.io_ack = 1'b0;
      chk("spurious_ack ignored", 32'(bad), 32'd0);
      dly_rd = 1; dly_wr = 0; rdata_cfg = 8'h04;
      clear_bus_log();
      exp_q.delete();
      exp_q.push_back(8'h55);
      exp_q.push_back(8'h66);
      bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_addr = 8'h55;
      bus.req_bitsel = 3'd2; bus.req_bitval = 1'b0;
      for (int c = 0; c < 30; c++) begin
        if (busy && bus.req_ready) ready_bad++;
        if (bus.rsp_valid) begin
          got_bits.push_back(bus.rsp_bit);
          busy = 1'b0;
        end
        bus_sample();
        take = bus.req_valid && bus.req_ready;
        @(posedge clk); #1;
        if (take) begin
          accepts++;
          busy = 1'b1;
          if (accepts == 1) begin
            bus.req_addr = 8'h66;
            bus.req_bitsel = 3'd5;
          end else begin
            bus.req_valid = 1'b0;
          end
        end
      end
      chk("b2b accepts", 32'(accepts), 32'd2);
      chk("b2b io_acks", 32'(n_ack), 32'd2);
      chk("b2b rsp_count", 32'(got_bits.size()), 32'd2);
      if (got_bits.size() == 2) begin
        chk("b2b rsp_bit0", 32'(got_bits[0]), 32'd1);
        chk("b2b rsp_bit1", 32'(got_bits[1]), 32'd0);
      end
      chk("b2b ready_low_busy", 32'(ready_bad), 32'd0);
      foreach (addr_log[i]) begin
        if (exp_q.size() == 0) chk("b2b extra_addr", 32'(addr_log[i]), 32'hFFFF_FFFF);
        else chk("b2b io_addr", 32'(addr_log[i]), 32'(exp_q.pop_front()));
      end
      chk("b2b addr_left", 32'(exp_q.size()), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/gmcu_bitio_ctrl.md
GMCU_BITIO_CTRL -- requirements
Module: gmcu_bitio_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, IO address width.
REQ-002 SHALL have parameter DATA_W, default 8, IO data width; must be a power of 2, at least 2.
REQ-003 SHALL have parameter TMO_CYC, default 15, bus-timeout limit in cycles; used only with the timeout macro.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port req_valid  in  1  bit-op request from decode (ldBitFromIo | stBitToIo).
REQ-007 SHALL have port req_ready  out  1  controller can accept a request.
REQ-008 SHALL have port req_store  in  1  1 = store bit to IO, 0 = load bit from IO.
REQ-009 SHALL have port req_addr  in  ADDR_W  IO register address.
REQ-010 SHALL have port req_bitsel  in  $clog2(DATA_W)  bit index within the register.
REQ-011 SHALL have port req_bitval  in  1  bit value for a store.
REQ-012 SHALL have port rsp_valid  out  1  one-cycle completion pulse.
REQ-013 SHALL have port rsp_bit  out  1  loaded bit for a load; value written for a store.
REQ-014 SHALL have port rsp_err  out  1  operation abandoned on timeout.
REQ-015 SHALL have ports io_req out 1, io_we out 1, io_addr out ADDR_W, io_wdata out DATA_W, io_ack in 1, io_rdata in DATA_W: an IO bus with a request/acknowledge handshake.

Function
REQ-016 SHALL implement states IDLE, RD, WR and RSP; req_ready = (state == IDLE).
REQ-017 SHALL capture addr, bitsel, bitval and store when req_valid & req_ready, then go IDLE->RD.
REQ-018 SHALL drive io_req=1 in RD/WR; io_we=1 only in WR; io_addr = captured addr throughout; io_addr, io_we and io_wdata are held stable while io_req=1.
REQ-019 SHALL treat io_ack as valid only in RD/WR and sampled while io_req=1; io_ack in IDLE/RSP is ignored.
REQ-020 SHALL on RD & io_ack: for a load, register rsp_bit = io_rdata[bitsel] and go to RSP; for a store, register io_wdata = io_rdata with bit bitsel replaced by bitval and go to WR.
REQ-021 SHALL on WR & io_ack go to RSP.
REQ-022 SHALL in RSP assert rsp_valid for exactly one cycle, then go to IDLE; rsp_valid has no backpressure.
REQ-023 SHALL meet minimum latency, with the accept edge at cycle 0 and zero-wait acks: load rsp_valid in cycle 2; store rsp_valid in cycle 3.
REQ-024 SHALL let io_req fall in the cycle after an acked cycle; back-to-back requests are separated by at least one IDLE cycle.

Reset
REQ-025 SHALL, when rst_n=0 at a clock edge, force IDLE and zero all outputs except req_ready, which is 1 after that edge: io_req, io_we, io_addr, io_wdata, rsp_valid, rsp_bit and rsp_err = 0.
REQ-026 SHALL abandon an operation in flight when reset is applied: no rsp_valid, and io_req low after the reset edge.

Configuration
REQ-027 SHALL, with GMCU_BITIO_TIMEOUT_EN defined, count consecutive RD/WR cycles without io_ack.
REQ-028 SHALL restart that count on each entry to RD or WR.
REQ-029 SHALL, when the count reaches TMO_CYC, leave RD/WR for RSP with rsp_err=1 and rsp_bit=0; a store timing out in RD never enters WR.
REQ-030 SHALL, without GMCU_BITIO_TIMEOUT_EN, wait indefinitely for io_ack, tie rsp_err to 0, and create no counter logic.

Structure
REQ-031 SHALL take the state typedef bitioStateType and the request struct bitioReqType (addr, bitsel, bitval, store) from gmcupkg.
REQ-032 SHALL place the timeout counter in sub-module gmcu_bitio_tmo (ports: clk, rst_n, start, run, expired), instantiated only under GMCU_BITIO_TIMEOUT_EN.

Verification
REQ-033 SHALL test: load, addr 0x12, bitsel 3, io_rdata 0x08, zero-wait ack -> rsp_valid in cycle 2, rsp_bit=1, rsp_err=0.
REQ-034 SHALL test: store, addr 0x20, bitsel 0, bitval 1, io_rdata 0xA4 -> one write with io_wdata=0xA5 and io_we=1, rsp_valid in cycle 3.
REQ-035 SHALL test: store, bitsel 7, bitval 0, io_rdata 0xFF, ack delayed 4 cycles in both RD and WR -> io_wdata=0x7F, bus signals stable while waiting, rsp_valid once.
REQ-036 SHALL test: with GMCU_BITIO_TIMEOUT_EN and TMO_CYC=15, no io_ack during a load -> rsp_err=1 after 15 RD cycles, no write, io_req=0 next cycle.
REQ-037 SHALL test: rst_n=0 for 1 cycle while in WR -> io_req=0 and req_ready=1 after the edge, and no rsp_valid.
REQ-038 SHALL test: spurious io_ack in IDLE, then req_valid held high for two requests -> ack ignored, two separate transactions, req_ready low during each.
